// File: rtl/idecode.sv
// RV32I decode stage: control decode, immediate extend, register file
// with write-through bypass, and a flushable ID/EX pipeline register.
module idecode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  input  logic        FlushE,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        JumpE,
  output logic        BranchE,
  output logic        ALUSrcE,
  output logic [1:0]  ResultSrcE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  logic [6:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        funct7b5;

  assign op       = InstrD[6:0];
  assign rd       = InstrD[11:7];
  assign funct3   = InstrD[14:12];
  assign rs1      = InstrD[19:15];
  assign rs2      = InstrD[24:20];
  assign funct7b5 = InstrD[30];

  logic       reg_write, mem_write, jump, branch, alu_src;
  logic [1:0] imm_src, result_src, alu_op;
  logic [2:0] alu_ctrl;

  // Unknown opcodes fall through to the all-zero defaults (a NOP).
  always_comb begin
    reg_write  = 1'b0;
    imm_src    = 2'b00;
    alu_src    = 1'b0;
    mem_write  = 1'b0;
    result_src = 2'b00;
    branch     = 1'b0;
    alu_op     = 2'b00;
    jump       = 1'b0;
    case (op)
      7'b0000011: begin
        reg_write  = 1'b1;
        alu_src    = 1'b1;
        result_src = 2'b01;
      end
      7'b0100011: begin
        imm_src   = 2'b01;
        alu_src   = 1'b1;
        mem_write = 1'b1;
      end
      7'b0110011: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
      end
      7'b1100011: begin
        imm_src = 2'b10;
        branch  = 1'b1;
        alu_op  = 2'b01;
      end
      7'b0010011: begin
        reg_write = 1'b1;
        alu_src   = 1'b1;
        alu_op    = 2'b10;
      end
      7'b1101111: begin
        reg_write  = 1'b1;
        imm_src    = 2'b11;
        result_src = 2'b10;
        jump       = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    alu_ctrl = 3'b000;
    case (alu_op)
      2'b01: alu_ctrl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  alu_ctrl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
          3'b010:  alu_ctrl = 3'b101;
          3'b110:  alu_ctrl = 3'b011;
          3'b111:  alu_ctrl = 3'b010;
          default: alu_ctrl = 3'b000;
        endcase
      end
      default: ;
    endcase
  end

  logic [31:0] imm_ext;

  always_comb begin
    imm_ext = '0;
    case (imm_src)
      2'b00: imm_ext = {{20{InstrD[31]}}, InstrD[31:20]};
      2'b01: imm_ext = {{20{InstrD[31]}}, InstrD[31:25],
                        InstrD[11:7]};
      2'b10: imm_ext = {{20{InstrD[31]}}, InstrD[7],
                        InstrD[30:25], InstrD[11:8], 1'b0};
      2'b11: imm_ext = {{12{InstrD[31]}}, InstrD[19:12],
                        InstrD[20], InstrD[30:21], 1'b0};
      default: ;
    endcase
  end

  logic [31:0] rf_q [32];
  logic [31:0] rf_d [32];
  logic        we;
  logic [31:0] rd1, rd2;

  assign we = RegWriteW && (RdW != 5'd0);

  always_comb begin
    rf_d = rf_q;
    if (we) rf_d[RdW] = ResultW;
    rf_d[0] = '0;
  end

  // Bypass lets the decoded instruction see this cycle's writeback.
  always_comb begin
    rd1 = rf_q[rs1];
    rd2 = rf_q[rs2];
    if (we && RdW == rs1) rd1 = ResultW;
    if (we && RdW == rs2) rd2 = ResultW;
    if (rs1 == 5'd0) rd1 = '0;
    if (rs2 == 5'd0) rd2 = '0;
  end

  id_ex_t ex_d, ex_q;

  always_comb begin
    ex_d = '{
      reg_write:  reg_write,
      mem_write:  mem_write,
      jump:       jump,
      branch:     branch,
      alu_src:    alu_src,
      result_src: result_src,
      alu_ctrl:   alu_ctrl,
      rd1:        rd1,
      rd2:        rd2,
      imm:        imm_ext,
      pc:         PCD,
      pc_plus4:   PCPlus4D,
      rs1:        rs1,
      rs2:        rs2,
      rd:         rd
    };
    if (FlushE) ex_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q <= '0;
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else begin
      ex_q <= ex_d;
      rf_q <= rf_d;
    end
  end

  assign RegWriteE   = ex_q.reg_write;
  assign MemWriteE   = ex_q.mem_write;
  assign JumpE       = ex_q.jump;
  assign BranchE     = ex_q.branch;
  assign ALUSrcE     = ex_q.alu_src;
  assign ResultSrcE  = ex_q.result_src;
  assign ALUControlE = ex_q.alu_ctrl;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;

endmodule
